// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq -- multi-cycle 32-bit barrel-shift replacement.
//
// Accepts one shift/rotate request while idle, then shifts an accumulator by
// one bit per clock until the requested amount is consumed. A one-cycle done
// pulse marks completion; result keeps the final value until the next
// accepted request.
//
// Ports:
//   clk      in   1   clock, all state changes on the rising edge
//   reset    in   1   synchronous, active-high reset
//   start    in   1   request a shift (only honoured while idle)
//   op       in   2   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   shamt    in   5   shift amount 0..31
//   data_in  in  32   operand
//   busy     out  1   high in SHIFT and DONE
//   done     out  1   one-cycle completion pulse
//   result   out 32   accumulator contents
//
// Handshake: start is a request qualified by busy=0. A start seen while
// busy=1 (including the DONE cycle) is dropped, never queued. done is a
// single-cycle strobe; result is valid with done and held afterwards.
// -----------------------------------------------------------------------------
module shift_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  shamt,
    input  logic [31:0] data_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    // state_q is left as a named internal signal so checkers can bind to it.
    state_e      state_q, state_d;
    logic [31:0] acc_q,   acc_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [1:0]  op_q,    op_d;

    // One-bit step of the latched operation.
    logic [31:0] acc_step;

    always_comb begin
        acc_step = acc_q;
        case (op_q)
            OP_SLL:  acc_step = {acc_q[30:0], 1'b0};
            OP_SRL:  acc_step = {1'b0, acc_q[31:1]};
            OP_SRA:  acc_step = {acc_q[31], acc_q[31:1]};
            OP_ROR:  acc_step = {acc_q[0], acc_q[31:1]};
            default: acc_step = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = data_in;
                    cnt_d   = shamt;
                    op_d    = op;
                    state_d = (shamt == 5'd0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_step;
                // Saturating decrement: count never wraps below zero.
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end
                // The edge that sees count==1 performs the last shift.
                if (cnt_q <= 5'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= 32'h0000_0000;
            cnt_q   <= 5'd0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    // Outputs come straight from registers: no path from start to done.
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = acc_q;

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] data_in;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int compared = 0;
  int mism     = 0;
  int cyc      = 0;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_run_q[$];

  shift_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [4:0] s,
                                            input logic [31:0] d);
    logic [31:0] r;
    case (o)
      2'b00: r = d << s;
      2'b01: r = d >> s;
      2'b10: r = $signed(d) >>> s;
      default: r = (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d,
                       input logic [31:0] exp, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      compared++;
      mism++;
      $display("FAIL issue_wait_idle: busy=%b after %0d cycles, expected 0", busy, n);
      return;
    end
    start   = 1'b1;
    op      = o;
    shamt   = s;
    data_in = d;
    if (push) begin
      exp_q.push_back(exp);
      exp_cyc_q.push_back(cyc + 1 + int'(s));
      exp_run_q.push_back(int'(s) + 1);
    end
    @(posedge clk);
    #1;
    // Scramble operands after acceptance; the operation in flight must not care.
    start   = 1'b0;
    op      = 2'($urandom_range(3, 0));
    shamt   = 5'($urandom_range(31, 0));
    data_in = $urandom;
  endtask

  task automatic poke_start();
    @(negedge clk);
    start   = 1'b1;
    op      = 2'($urandom_range(3, 0));
    shamt   = 5'($urandom_range(31, 0));
    data_in = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done_then_poke();
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      compared++;
      mism++;
      $display("FAIL wait_done: done=%b after %0d cycles, expected 1", done, n);
      return;
    end
    // Present start in the DONE cycle only, dropped before the IDLE edge.
    start   = 1'b1;
    op      = 2'b00;
    shamt   = 5'd3;
    data_in = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          busy_run = 0;
  bit          hold_chk = 1'b0;
  logic [31:0] last_res = '0;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mism++;
          $display("FAIL unexpected_done: result 0x%08h at cycle %0d, expected no done", result, cyc);
        end else begin
          logic [31:0] e;
          int ec;
          int er;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          er = exp_run_q.pop_front();
          check("result", result, e);
          compared++;
          if (cyc != ec) begin
            mism++;
            $display("FAIL done_latency: done at cycle %0d expected cycle %0d", cyc, ec);
          end
          compared++;
          if (busy_run + 1 != er) begin
            mism++;
            $display("FAIL busy_length: busy high %0d cycles expected %0d", busy_run + 1, er);
          end
        end
        last_res = result;
        hold_chk = 1'b1;
      end else if (busy === 1'b1) begin
        hold_chk = 1'b0;
      end else if (hold_chk) begin
        check("result_hold_idle", result, last_res);
      end
    end else begin
      hold_chk = 1'b0;
    end
    if (busy === 1'b1) busy_run++;
    else busy_run = 0;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset   = 1'b1;
    start   = 1'b0;
    op      = 2'b00;
    shamt   = 5'd0;
    data_in = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {31'h0, busy}, 32'h0);
    check("reset_done",   {31'h0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    reset = 1'b0;

    // Directed vectors, hand-computed expectations.
    issue(2'b00, 5'd4,  32'h0000_0001, 32'h0000_0010, 1'b1);
    issue(2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b1);
    issue(2'b11, 5'd1,  32'h0000_0001, 32'h8000_0000, 1'b1);
    issue(2'b11, 5'd8,  32'h1234_5678, 32'h7812_3456, 1'b1);
    issue(2'b00, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    repeat (4) @(negedge clk);

    // Starts during SHIFT and during DONE must be dropped.
    issue(2'b00, 5'd8, 32'h0000_0001, 32'h0000_0100, 1'b1);
    poke_start();
    poke_start();
    wait_done_then_poke();
    repeat (6) @(negedge clk);

    // Reset mid-SHIFT: everything to zero, no done pulse.
    issue(2'b00, 5'd10, 32'h0000_0001, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy",   {31'h0, busy}, 32'h0);
    check("abort_done",   {31'h0, done}, 32'h0);
    check("abort_result", result, 32'h0);
    repeat (15) @(negedge clk);

    // Random operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  ro;
      logic [4:0]  rs;
      logic [31:0] rd;
      ro = 2'($urandom_range(3, 0));
      rs = 5'($urandom_range(31, 0));
      rd = $urandom;
      if (i < 4) rs = 5'(31 * (i % 2));
      issue(ro, rs, rd, ref_shift(ro, rs, rd), 1'b1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mism++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
